serial_rom_loader_ctrl: RTL and testbench

Sequences a ROM download arriving as a byte stream from the serial front end (restart strobe plus data/valid) into main memory.
- Parses the 32-byte SNES header and derives the body length.
- Buffers body bytes in a small FIFO and issues one req/ack write per byte.
- Drives the `loading` status back to the serial front end and the rest of the system.

---
 rtl/loader_pkg.sv | 27 ++
 rtl/loader_byte_fifo.sv | 67 ++++++
 rtl/serial_rom_loader_ctrl.sv | 198 +++++++++++++++++++
 tb/tb_serial_rom_loader_ctrl.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/loader_pkg.sv
// ---------------------------------------------------------------------------
// loader_pkg
// Shared types and constants for the serial ROM loader.
//   state_t      : loader sequencing states
//   HDR_*        : byte offsets inside the 32-byte SNES header
//   BODY_UNIT    : body length granule, total body = BODY_UNIT << size_log
// ---------------------------------------------------------------------------
package loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HEADER,
        BODY,
        DRAIN,
        DONE
    } state_t;

    localparam int         HDR_LEN     = 32;
    localparam logic [4:0] HDR_MAP     = 5'h15;
    localparam logic [4:0] HDR_TYPE    = 5'h16;
    localparam logic [4:0] HDR_SIZE    = 5'h17;
    localparam logic [4:0] HDR_CSUM_LO = 5'h1E;
    localparam logic [4:0] HDR_CSUM_HI = 5'h1F;

    localparam int         BODY_UNIT   = 1024;

endpackage

// File: rtl/loader_byte_fifo.sv
// ---------------------------------------------------------------------------
// loader_byte_fifo
// Small synchronous byte FIFO buffering ROM body bytes ahead of the memory
// write port. dout shows the head entry whenever empty = 0 (show-ahead).
// A push while full is accepted only when a pop happens in the same cycle.
// Ports:
//   clk, resetn      : clock, synchronous active-low reset
//   flush            : drop all contents (takes priority over push/pop)
//   push, din        : write side
//   pop, dout        : read side
//   empty, full      : occupancy flags
// ---------------------------------------------------------------------------
module loader_byte_fifo #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       flush,
    input  logic       push,
    input  logic [7:0] din,
    input  logic       pop,
    output logic [7:0] dout,
    output logic       empty,
    output logic       full
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [7:0]       mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [PTR_W:0]   count_reg;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count_reg == '0);
    assign full    = (count_reg == (PTR_W+1)'(DEPTH));
    assign dout    = mem[rd_ptr_reg];
    assign do_pop  = pop && !empty && !flush;
    assign do_push = push && !flush && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn || flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + (PTR_W+1)'(1);
                2'b01:   count_reg <= count_reg - (PTR_W+1)'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/serial_rom_loader_ctrl.sv
// ---------------------------------------------------------------------------
// serial_rom_loader_ctrl
// Takes a ROM download from the serial front end, parses the 32-byte SNES
// header, then streams the body (1024 << size_log bytes) into main memory
// through a small FIFO and a req/ack byte write port.
// Ports:
//   clk, resetn                  : clock, synchronous active-low reset
//   serial_reset                 : one-cycle restart strobe (wins over data)
//   serial_data/_valid           : incoming byte stream
//   loading                      : high from restart until body written
//   mem_req/addr/din, mem_ack    : memory write handshake
//   map_mode, rom_type           : header bytes 0x15 / 0x16
//   rom_size_log                 : header byte 0x17, clamped to MAX_SIZE_LOG
//   load_done                    : one-cycle completion pulse
//   err_overrun, err_size        : sticky error flags, cleared on restart
//   checksum_ok                  : body checksum result
// Build option: define LOADER_CHECKSUM_EN to compare a 16-bit body sum with
// header bytes 0x1E/0x1F at completion; otherwise checksum_ok is tied high.
// ---------------------------------------------------------------------------
module serial_rom_loader_ctrl
    import loader_pkg::*;
#(
    parameter int ADDR_W       = 23,
    parameter int FIFO_DEPTH   = 4,
    parameter int MAX_SIZE_LOG = 13
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              serial_reset,
    input  logic [7:0]        serial_data,
    input  logic              serial_data_valid,
    output logic              loading,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_din,
    input  logic              mem_ack,
    output logic [7:0]        map_mode,
    output logic [7:0]        rom_type,
    output logic [3:0]        rom_size_log,
    output logic              load_done,
    output logic              err_overrun,
    output logic              err_size,
    output logic              checksum_ok
);
    localparam int         CNT_W         = ADDR_W + 1;
    localparam logic [7:0] MAX_SIZE_BYTE = 8'(MAX_SIZE_LOG);

    state_t           state_reg;
    logic [4:0]       hdr_cnt_reg;
    logic [CNT_W-1:0] body_cnt_reg;
    logic [CNT_W-1:0] body_total;
    logic             byte_in_body;
    logic             overrun;
    logic             fifo_push;
    logic             fifo_pop;
    logic             fifo_empty;
    logic             fifo_full;
    logic [7:0]       fifo_dout;

    assign body_total   = CNT_W'(BODY_UNIT) << rom_size_log;
    assign byte_in_body = serial_data_valid && !serial_reset && (state_reg == BODY);
    assign fifo_push    = byte_in_body;
    // Issue the next write whenever the port is free or being freed this cycle.
    assign fifo_pop     = !fifo_empty && (!mem_req || mem_ack) && !serial_reset;
    // A full FIFO still takes the byte if the head leaves in the same cycle.
    assign overrun      = byte_in_body && fifo_full && !fifo_pop;

`ifdef LOADER_CHECKSUM_EN
    logic [15:0] csum_sum_reg;
    logic [15:0] csum_exp_reg;
    logic        checksum_ok_reg;
    assign checksum_ok = checksum_ok_reg;
`else
    assign checksum_ok = 1'b1;
`endif

    loader_byte_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk    (clk),
        .resetn (resetn),
        .flush  (serial_reset),
        .push   (fifo_push),
        .din    (serial_data),
        .pop    (fifo_pop),
        .dout   (fifo_dout),
        .empty  (fifo_empty),
        .full   (fifo_full)
    );

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_reg    <= IDLE;
            hdr_cnt_reg  <= '0;
            body_cnt_reg <= '0;
            loading      <= 1'b0;
            mem_req      <= 1'b0;
            mem_addr     <= '0;
            mem_din      <= '0;
            map_mode     <= '0;
            rom_type     <= '0;
            rom_size_log <= '0;
            load_done    <= 1'b0;
            err_overrun  <= 1'b0;
            err_size     <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            csum_sum_reg    <= '0;
            csum_exp_reg    <= '0;
            checksum_ok_reg <= 1'b1;
`endif
        end else if (serial_reset) begin
            // Restart: any byte in this cycle and any later stale ack are lost.
            state_reg    <= HEADER;
            hdr_cnt_reg  <= '0;
            body_cnt_reg <= '0;
            loading      <= 1'b1;
            mem_req      <= 1'b0;
            mem_addr     <= '0;
            load_done    <= 1'b0;
            err_overrun  <= 1'b0;
            err_size     <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            csum_sum_reg    <= '0;
            checksum_ok_reg <= 1'b0;
`endif
        end else begin
            load_done <= 1'b0;

            // Memory write port: address advances only on an acked request.
            if (mem_req && mem_ack) begin
                mem_addr <= mem_addr + ADDR_W'(1);
            end
            if (fifo_pop) begin
                mem_req <= 1'b1;
                mem_din <= fifo_dout;
            end else if (mem_ack) begin
                mem_req <= 1'b0;
            end

            if (overrun) begin
                err_overrun <= 1'b1;
            end

            case (state_reg)
                HEADER: begin
                    if (serial_data_valid) begin
                        hdr_cnt_reg <= hdr_cnt_reg + 5'd1;
                        case (hdr_cnt_reg)
                            HDR_MAP:  map_mode <= serial_data;
                            HDR_TYPE: rom_type <= serial_data;
                            HDR_SIZE: begin
                                if (serial_data > MAX_SIZE_BYTE) begin
                                    rom_size_log <= MAX_SIZE_BYTE[3:0];
                                    err_size     <= 1'b1;
                                end else begin
                                    rom_size_log <= serial_data[3:0];
                                end
                            end
`ifdef LOADER_CHECKSUM_EN
                            HDR_CSUM_LO: csum_exp_reg[7:0]  <= serial_data;
                            HDR_CSUM_HI: csum_exp_reg[15:8] <= serial_data;
`endif
                            default: ;
                        endcase
                        if (hdr_cnt_reg == 5'(HDR_LEN - 1)) begin
                            state_reg <= BODY;
                        end
                    end
                end
                BODY: begin
                    if (serial_data_valid) begin
                        // Dropped bytes are still counted so the load always ends.
                        body_cnt_reg <= body_cnt_reg + CNT_W'(1);
`ifdef LOADER_CHECKSUM_EN
                        csum_sum_reg <= csum_sum_reg + {8'd0, serial_data};
`endif
                        if (body_cnt_reg == body_total - CNT_W'(1)) begin
                            state_reg <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (fifo_empty && !mem_req) begin
                        state_reg <= DONE;
                        load_done <= 1'b1;
                        loading   <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
                        checksum_ok_reg <= (csum_sum_reg == csum_exp_reg);
`endif
                    end
                end
                DONE:    state_reg <= IDLE;
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_rom_loader_ctrl.sv
// ---------------------------------------------------------------------------
// tb_serial_rom_loader_ctrl
// Directed bench for serial_rom_loader_ctrl. A negedge process plays the
// memory (configurable ack delay, logs every acked write) and watches
// load_done and request stability; scenario tasks drive the serial side
// and compare outputs against hand-derived values.
// ---------------------------------------------------------------------------
module tb_serial_rom_loader_ctrl;
    localparam int ADDR_W = 23;

    logic              clk               = 1'b0;
    logic              resetn            = 1'b0;
    logic              serial_reset      = 1'b0;
    logic [7:0]        serial_data       = 8'h00;
    logic              serial_data_valid = 1'b0;
    logic              loading;
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_din;
    logic              mem_ack           = 1'b0;
    logic [7:0]        map_mode;
    logic [7:0]        rom_type;
    logic [3:0]        rom_size_log;
    logic              load_done;
    logic              err_overrun;
    logic              err_size;
    logic              checksum_ok;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    serial_rom_loader_ctrl #(
        .ADDR_W       (ADDR_W),
        .FIFO_DEPTH   (4),
        .MAX_SIZE_LOG (13)
    ) dut (
        .clk               (clk),
        .resetn            (resetn),
        .serial_reset      (serial_reset),
        .serial_data       (serial_data),
        .serial_data_valid (serial_data_valid),
        .loading           (loading),
        .mem_req           (mem_req),
        .mem_addr          (mem_addr),
        .mem_din           (mem_din),
        .mem_ack           (mem_ack),
        .map_mode          (map_mode),
        .rom_type          (rom_type),
        .rom_size_log      (rom_size_log),
        .load_done         (load_done),
        .err_overrun       (err_overrun),
        .err_size          (err_size),
        .checksum_ok       (checksum_ok)
    );

    // ---------------- memory model and monitor ----------------
    int                ack_delay  = 1;
    int                ack_cnt    = 0;
    int                stray_req  = 0;
    int                stray_seen = 0;
    int                done_count = 0;
    int                done_while_loading = 0;
    int                unstable   = 0;
    logic [ADDR_W-1:0] log_addr[$];
    logic [7:0]        log_data[$];
    logic              prev_req  = 1'b0;
    logic              prev_ack  = 1'b0;
    logic [ADDR_W-1:0] prev_addr = '0;
    logic [7:0]        prev_din  = '0;

    always @(negedge clk) begin
        if (load_done === 1'b1) begin
            done_count++;
            if (loading !== 1'b0) done_while_loading++;
        end
        if (prev_req && !prev_ack && mem_req === 1'b1 &&
            (mem_addr !== prev_addr || mem_din !== prev_din)) begin
            unstable++;
        end
        prev_req  = (mem_req === 1'b1);
        prev_addr = mem_addr;
        prev_din  = mem_din;

        if (mem_ack) begin
            mem_ack = 1'b0;
            ack_cnt = 0;
        end else if (stray_req != stray_seen) begin
            mem_ack = 1'b1;
            stray_seen++;
        end else if (mem_req === 1'b1) begin
            if (ack_cnt >= ack_delay) begin
                log_addr.push_back(mem_addr);
                log_data.push_back(mem_din);
                mem_ack = 1'b1;
            end else begin
                ack_cnt++;
            end
        end else begin
            ack_cnt = 0;
        end
        prev_ack = mem_ack;
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_restart();
        serial_reset = 1'b1;
        tick();
        serial_reset = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        serial_data       = b;
        serial_data_valid = 1'b1;
        tick();
        serial_data_valid = 1'b0;
        repeat (gap) tick();
    endtask

    task automatic send_header(input logic [7:0] mm, input logic [7:0] rt,
                               input logic [7:0] sz, input logic [15:0] cs);
        logic [7:0] b;
        for (int i = 0; i < 32; i++) begin
            case (i)
                'h15:    b = mm;
                'h16:    b = rt;
                'h17:    b = sz;
                'h1E:    b = cs[7:0];
                'h1F:    b = cs[15:8];
                default: b = 8'(8'hC0 + i);
            endcase
            send_byte(b, 0);
        end
    endtask

    task automatic send_body(input int n, input int gap, input int corrupt);
        for (int i = 0; i < n; i++) begin
            send_byte((i == corrupt) ? 8'h00 : 8'(i), gap);
        end
    endtask

    task automatic wait_done(input int base, input string name);
        int c = 0;
        while (done_count == base && c < 30000) begin
            tick();
            c++;
        end
        n_cmp++;
        if (done_count == base) begin
            n_err++;
            $display("FAIL %s_timeout: load_done pulses=%0d, required 1", name, done_count - base);
        end
        repeat (20) tick();
    endtask

    // Writes from log index base that deviate from addr k / data k&0xFF.
    function automatic int count_bad(input int base, input int n, input bit chk_data,
                                     input int corrupt);
        int bad = 0;
        for (int k = 0; k < n; k++) begin
            if (base + k >= log_addr.size()) begin
                bad++;
            end else if (log_addr[base+k] !== ADDR_W'(k)) begin
                bad++;
            end else if (chk_data &&
                         log_data[base+k] !== ((k == corrupt) ? 8'h00 : 8'(k))) begin
                bad++;
            end
        end
        return bad;
    endfunction

    // ---------------- scenarios ----------------
    task automatic test_reset();
        resetn = 1'b0;
        repeat (3) tick();
        resetn = 1'b1;
        tick();
        n_cmp++; if (loading !== 1'b0) begin n_err++; $display("FAIL rst_loading: got %b, want 0", loading); end
        n_cmp++; if (mem_req !== 1'b0) begin n_err++; $display("FAIL rst_mem_req: got %b, want 0", mem_req); end
        n_cmp++; if (mem_addr !== '0) begin n_err++; $display("FAIL rst_mem_addr: got %h, want 0", mem_addr); end
        n_cmp++; if (load_done !== 1'b0) begin n_err++; $display("FAIL rst_load_done: got %b, want 0", load_done); end
        n_cmp++; if ({err_overrun, err_size} !== 2'b00) begin n_err++; $display("FAIL rst_errs: got %b%b, want 00", err_overrun, err_size); end
        n_cmp++; if ({map_mode, rom_type, rom_size_log} !== 20'h0) begin n_err++; $display("FAIL rst_hdr: got %h %h %h, want 0 0 0", map_mode, rom_type, rom_size_log); end
        n_cmp++; if (checksum_ok !== 1'b1) begin n_err++; $display("FAIL rst_checksum_ok: got %b, want 1", checksum_ok); end
        // Bytes in IDLE are ignored.
        send_byte(8'h55, 0);
        send_byte(8'h66, 0);
        repeat (3) tick();
        n_cmp++; if (loading !== 1'b0 || mem_req !== 1'b0) begin n_err++; $display("FAIL idle_ignore: loading=%b mem_req=%b, want 0 0", loading, mem_req); end
        $display("test_reset done");
    endtask

    task automatic test_basic_load();
        int base_log;
        int base_done;
        int bad;
        ack_delay = 1;
        do_restart();
        n_cmp++; if (loading !== 1'b1) begin n_err++; $display("FAIL basic_loading_start: got %b, want 1", loading); end
        base_log  = log_addr.size();
        base_done = done_count;
        // Sum of 1024 bytes i&0xFF = 4 * 0x7F80 = 0x1FE00 -> 0xFE00 (16-bit).
        send_header(8'h21, 8'h02, 8'h00, 16'hFE00);
        n_cmp++; if (rom_size_log !== 4'd0 || err_size !== 1'b0) begin n_err++; $display("FAIL basic_size: got %0d/%b, want 0/0", rom_size_log, err_size); end
        send_body(1024, 4, -1);
        wait_done(base_done, "basic");
        bad = count_bad(base_log, 1024, 1'b1, -1);
        n_cmp++; if (log_addr.size() - base_log !== 1024) begin n_err++; $display("FAIL basic_write_count: got %0d, want 1024", log_addr.size() - base_log); end
        n_cmp++; if (bad !== 0) begin n_err++; $display("FAIL basic_write_content: bad writes %0d, want 0", bad); end
        n_cmp++; if (done_count - base_done !== 1) begin n_err++; $display("FAIL basic_done_once: got %0d, want 1", done_count - base_done); end
        n_cmp++; if (done_while_loading !== 0) begin n_err++; $display("FAIL basic_done_loading: loading high at done %0d times, want 0", done_while_loading); end
        n_cmp++; if (loading !== 1'b0) begin n_err++; $display("FAIL basic_loading_end: got %b, want 0", loading); end
        n_cmp++; if (map_mode !== 8'h21 || rom_type !== 8'h02) begin n_err++; $display("FAIL basic_hdr: got %h %h, want 21 02", map_mode, rom_type); end
        n_cmp++; if (err_overrun !== 1'b0) begin n_err++; $display("FAIL basic_overrun: got %b, want 0", err_overrun); end
        n_cmp++; if (checksum_ok !== 1'b1) begin n_err++; $display("FAIL basic_checksum: got %b, want 1", checksum_ok); end
        n_cmp++; if (unstable !== 0) begin n_err++; $display("FAIL basic_req_stable: changes while held %0d, want 0", unstable); end
        $display("test_basic_load done: %0d writes", log_addr.size() - base_log);
    endtask

    task automatic test_overrun();
        int base_log;
        int base_done;
        int n;
        ack_delay = 20;
        do_restart();
        base_log  = log_addr.size();
        base_done = done_count;
        send_header(8'h31, 8'h03, 8'h00, 16'h0000);
        send_body(1024, 0, -1);
        n_cmp++; if (err_overrun !== 1'b1) begin n_err++; $display("FAIL ovr_flag: got %b, want 1", err_overrun); end
        wait_done(base_done, "overrun");
        n = log_addr.size() - base_log;
        n_cmp++; if (!(n > 0 && n < 1024)) begin n_err++; $display("FAIL ovr_write_count: got %0d, want 1..1023", n); end
        n_cmp++; if (count_bad(base_log, n, 1'b0, -1) !== 0) begin n_err++; $display("FAIL ovr_addr_seq: bad %0d, want 0", count_bad(base_log, n, 1'b0, -1)); end
        n_cmp++; if (done_count - base_done !== 1) begin n_err++; $display("FAIL ovr_done_once: got %0d, want 1", done_count - base_done); end
        n_cmp++; if (unstable !== 0) begin n_err++; $display("FAIL ovr_req_stable: changes while held %0d, want 0", unstable); end
        n_cmp++; if (loading !== 1'b0 || err_overrun !== 1'b1) begin n_err++; $display("FAIL ovr_end: loading=%b err=%b, want 0 1", loading, err_overrun); end
        $display("test_overrun done: %0d writes", n);
    endtask

    task automatic test_size_clamp();
        do_restart();
        send_header(8'h20, 8'h00, 8'h0F, 16'h0000);
        n_cmp++; if (rom_size_log !== 4'd13 || err_size !== 1'b1) begin n_err++; $display("FAIL clamp_0f: got %0d/%b, want 13/1", rom_size_log, err_size); end
        do_restart();
        n_cmp++; if (err_size !== 1'b0) begin n_err++; $display("FAIL clamp_clear: got %b, want 0", err_size); end
        send_header(8'h20, 8'h00, 8'h0D, 16'h0000);
        n_cmp++; if (rom_size_log !== 4'd13 || err_size !== 1'b0) begin n_err++; $display("FAIL clamp_0d: got %0d/%b, want 13/0", rom_size_log, err_size); end
        $display("test_size_clamp done");
    endtask

    task automatic test_restart_mid_body();
        int base_log;
        int base_done;
        ack_delay = 30;
        do_restart();
        send_header(8'h11, 8'h01, 8'h00, 16'h0000);
        // First body byte at cycle N: request must be up at N+2, not N+1.
        serial_data       = 8'h00;
        serial_data_valid = 1'b1;
        tick();
        serial_data_valid = 1'b0;
        n_cmp++; if (mem_req !== 1'b0) begin n_err++; $display("FAIL lat_n1: mem_req=%b, want 0", mem_req); end
        tick();
        n_cmp++; if (mem_req !== 1'b1 || mem_addr !== '0 || mem_din !== 8'h00) begin n_err++; $display("FAIL lat_n2: req=%b addr=%h din=%h, want 1 0 00", mem_req, mem_addr, mem_din); end
        for (int i = 1; i < 500; i++) send_byte(8'(i), 0);
        n_cmp++; if (loading !== 1'b1 || err_overrun !== 1'b1) begin n_err++; $display("FAIL mid_state: loading=%b ovr=%b, want 1 1", loading, err_overrun); end
        base_done = done_count;
        do_restart();
        stray_req++;
        n_cmp++; if (mem_req !== 1'b0 || err_overrun !== 1'b0 || loading !== 1'b1) begin n_err++; $display("FAIL restart_state: req=%b ovr=%b loading=%b, want 0 0 1", mem_req, err_overrun, loading); end
        repeat (3) tick();
        ack_delay = 1;
        base_log  = log_addr.size();
        send_header(8'h12, 8'h04, 8'h00, 16'hFE00);
        send_body(1024, 4, -1);
        wait_done(base_done, "restart");
        n_cmp++; if (log_addr.size() - base_log !== 1024) begin n_err++; $display("FAIL restart_write_count: got %0d, want 1024", log_addr.size() - base_log); end
        n_cmp++; if (count_bad(base_log, 1024, 1'b1, -1) !== 0) begin n_err++; $display("FAIL restart_content: bad %0d, want 0 (first addr must be 0)", count_bad(base_log, 1024, 1'b1, -1)); end
        n_cmp++; if (done_count - base_done !== 1) begin n_err++; $display("FAIL restart_done_once: got %0d, want 1", done_count - base_done); end
        $display("test_restart_mid_body done");
    endtask

    task automatic test_reset_collision();
        serial_data       = 8'h99;
        serial_data_valid = 1'b1;
        serial_reset      = 1'b1;
        tick();
        serial_reset      = 1'b0;
        serial_data_valid = 1'b0;
        send_header(8'h3C, 8'h5A, 8'h02, 16'h0000);
        n_cmp++; if (map_mode !== 8'h3C || rom_type !== 8'h5A) begin n_err++; $display("FAIL collide_hdr: got %h %h, want 3c 5a", map_mode, rom_type); end
        n_cmp++; if (rom_size_log !== 4'd2) begin n_err++; $display("FAIL collide_size: got %0d, want 2", rom_size_log); end
        $display("test_reset_collision done");
    endtask

    task automatic test_checksum();
        int base_log;
        int base_done;
        logic exp_ok;
`ifdef LOADER_CHECKSUM_EN
        exp_ok = 1'b0;
`else
        exp_ok = 1'b1;
`endif
        ack_delay = 1;
        do_restart();
        n_cmp++; if (checksum_ok !== exp_ok) begin n_err++; $display("FAIL csum_after_restart: got %b, want %b", checksum_ok, exp_ok); end
        base_log  = log_addr.size();
        base_done = done_count;
        send_header(8'h21, 8'h02, 8'h00, 16'hFE00);
        // Byte 7 replaced by 0: sum becomes 0xFDF9, no longer matching.
        send_body(1024, 4, 7);
        wait_done(base_done, "csum");
        n_cmp++; if (count_bad(base_log, 1024, 1'b1, 7) !== 0) begin n_err++; $display("FAIL csum_content: bad %0d, want 0", count_bad(base_log, 1024, 1'b1, 7)); end
        n_cmp++; if (checksum_ok !== exp_ok) begin n_err++; $display("FAIL csum_corrupt: got %b, want %b", checksum_ok, exp_ok); end
        $display("test_checksum done");
    endtask

    initial begin
        test_reset();
        test_basic_load();
        test_overrun();
        test_size_clamp();
        test_restart_mid_body();
        test_reset_collision();
        test_checksum();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
